// File: rtl/fft16_pkg.sv
// Shared widths, index type and presenter state encoding for the FFT16 frame loader.
package fft16_pkg;
  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned FRACTION  = 8;
  localparam int unsigned POINTS    = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned FRAME_W   = POINTS * WORD_SIZE;
  localparam int unsigned CNT_W     = 16;

  typedef logic [IDX_W-1:0] fft_idx_t;

  typedef enum logic {
    PRES_IDLE = 1'b0,
    PRES_HELD = 1'b1
  } pres_state_t;
endpackage

// File: rtl/fft16_frame_loader_if.sv
// Sample stream, frame output and FFT release handshake of the frame loader.
interface fft16_frame_loader_if;
  import fft16_pkg::*;

  logic [WORD_SIZE-1:0] i_sample_re;
  logic [WORD_SIZE-1:0] i_sample_im;
  logic                 i_sample_valid;
  logic                 o_sample_ready;
  logic [FRAME_W-1:0]   o_frame_re;
  logic [FRAME_W-1:0]   o_frame_im;
  logic                 o_frame_valid;
  logic                 o_frame_start;
  logic                 i_FFT_cycle_done;
  logic [CNT_W-1:0]     o_frames_done;

  modport master (
    output i_sample_re, i_sample_im, i_sample_valid, i_FFT_cycle_done,
    input  o_sample_ready, o_frame_re, o_frame_im, o_frame_valid,
           o_frame_start, o_frames_done
  );

  modport slave (
    input  i_sample_re, i_sample_im, i_sample_valid, i_FFT_cycle_done,
    output o_sample_ready, o_frame_re, o_frame_im, o_frame_valid,
           o_frame_start, o_frames_done
  );
endinterface

// File: rtl/fft16_frame_bank.sv
// 16-entry complex register file: one indexed write port, full frame read flattened.
module fft16_frame_bank
  import fft16_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  fft_idx_t             idx,
  input  logic [WORD_SIZE-1:0] re,
  input  logic [WORD_SIZE-1:0] im,
  output logic [FRAME_W-1:0]   frame_re,
  output logic [FRAME_W-1:0]   frame_im
);
  logic [WORD_SIZE-1:0] mem_re [POINTS];
  logic [WORD_SIZE-1:0] mem_im [POINTS];

  // Contents are never reset; the loader gates them off the outputs instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[idx] <= re;
      mem_im[idx] <= im;
    end
  end

  for (genvar k = 0; k < POINTS; k++) begin : g_flat
    assign frame_re[k*WORD_SIZE +: WORD_SIZE] = mem_re[k];
    assign frame_im[k*WORD_SIZE +: WORD_SIZE] = mem_im[k];
  end
endmodule

// File: rtl/fft16_frame_loader.sv
// Ping-pong frame loader: packs 16 streamed complex samples per bank and holds a full bank for the FFT.
module fft16_frame_loader
  import fft16_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  fft16_frame_loader_if.slave  bus
);
  pres_state_t       state_q, state_d;
  logic              fill_bank_q, fill_bank_d;
  fft_idx_t          wr_idx_q, wr_idx_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              pres_bank_q, pres_bank_d;
  logic              frame_start_q, frame_start_d;
  logic [CNT_W-1:0]  frames_done_q, frames_done_d;

  logic              sample_ready;
  logic              accept;
  logic              fill_done;
  logic              frame_release;
  logic              frame_present;
  logic [FRAME_W-1:0] bank_re [2];
  logic [FRAME_W-1:0] bank_im [2];

  assign sample_ready  = !bank_full_q[fill_bank_q];
  assign accept        = bus.i_sample_valid && sample_ready;
  assign fill_done     = accept && (wr_idx_q == IDX_W'(POINTS - 1));
  assign frame_release = (state_q == PRES_HELD) && bus.i_FFT_cycle_done;
  assign frame_present = (state_q == PRES_IDLE) && bank_full_q[pres_bank_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= PRES_IDLE;
      fill_bank_q   <= 1'b0;
      wr_idx_q      <= '0;
      bank_full_q   <= '0;
      pres_bank_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      fill_bank_q   <= fill_bank_d;
      wr_idx_q      <= wr_idx_d;
      bank_full_q   <= bank_full_d;
      pres_bank_q   <= pres_bank_d;
      frame_start_q <= frame_start_d;
      frames_done_q <= frames_done_d;
    end
  end

  // Fill and release never target the same bank, so both updates may land in one cycle.
  always_comb begin
    state_d       = state_q;
    fill_bank_d   = fill_bank_q;
    wr_idx_d      = wr_idx_q;
    bank_full_d   = bank_full_q;
    pres_bank_d   = pres_bank_q;
    frame_start_d = 1'b0;
    frames_done_d = frames_done_q;

    if (accept) begin
      wr_idx_d = IDX_W'(wr_idx_q + 1'b1);
    end
    if (fill_done) begin
      bank_full_d[fill_bank_q] = 1'b1;
      fill_bank_d              = !fill_bank_q;
    end

    case (state_q)
      PRES_IDLE: begin
        if (frame_present) begin
          state_d       = PRES_HELD;
          frame_start_d = 1'b1;
        end
      end
      PRES_HELD: begin
        if (frame_release) begin
          state_d                  = PRES_IDLE;
          bank_full_d[pres_bank_q] = 1'b0;
          pres_bank_d              = !pres_bank_q;
          frames_done_d            = CNT_W'(frames_done_q + 1'b1);
        end
      end
      default: state_d = PRES_IDLE;
    endcase
  end

  fft16_frame_bank u_bank0 (
    .clk      (i_clk),
    .we       (accept && !fill_bank_q && !i_rst),
    .idx      (wr_idx_q),
    .re       (bus.i_sample_re),
    .im       (bus.i_sample_im),
    .frame_re (bank_re[0]),
    .frame_im (bank_im[0])
  );

  fft16_frame_bank u_bank1 (
    .clk      (i_clk),
    .we       (accept && fill_bank_q && !i_rst),
    .idx      (wr_idx_q),
    .re       (bus.i_sample_re),
    .im       (bus.i_sample_im),
    .frame_re (bank_re[1]),
    .frame_im (bank_im[1])
  );

  // Frame bus reads zero unless a bank is held for the FFT.
  assign bus.o_sample_ready = sample_ready;
  assign bus.o_frame_valid  = (state_q == PRES_HELD);
  assign bus.o_frame_start  = frame_start_q;
  assign bus.o_frames_done  = frames_done_q;
  assign bus.o_frame_re     = (state_q == PRES_HELD) ? bank_re[pres_bank_q] : '0;
  assign bus.o_frame_im     = (state_q == PRES_HELD) ? bank_im[pres_bank_q] : '0;
endmodule

// File: tb/tb_fft16_frame_loader.sv
// Phase-table bench for the frame loader with a frame scoreboard and per-cycle reference checks.
module tb_fft16_frame_loader;
  import fft16_pkg::*;

  localparam int unsigned FW = FRAME_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft16_frame_loader_if bus();

  fft16_frame_loader dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_nfull = 0;
  int              m_widx  = 0;
  bit              m_held  = 1'b0;
  bit              m_start = 1'b0;
  logic [15:0]     m_cnt   = '0;
  logic [FW-1:0]   m_cur_re = '0;
  logic [FW-1:0]   m_cur_im = '0;
  logic [FW-1:0]   fq_re[$];
  logic [FW-1:0]   fq_im[$];
  int              seq = 0;

  typedef struct {
    int          cyc;
    bit          rst;
    bit          valid;
    bit          done;
    bit          e_ready;
    bit          e_valid;
    bit          e_start;
    logic [15:0] e_fd;
  } phase_t;

  phase_t ph[18];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_sample();
    bus.i_sample_re = 16'(seq * 256);
    bus.i_sample_im = 16'(-seq);
  endtask

  // One clock; model advances on the inputs held across the edge, then outputs are compared.
  task automatic step();
    bit acc, fill, rel, pres;
    logic [FW-1:0] exp_re, exp_im;
    @(posedge clk);
    #1;
    if (rst) begin
      m_nfull = 0; m_widx = 0; m_held = 1'b0; m_start = 1'b0; m_cnt = '0;
      m_cur_re = '0; m_cur_im = '0;
      fq_re.delete(); fq_im.delete();
    end else begin
      acc  = bus.i_sample_valid && (m_nfull < 2);
      fill = acc && (m_widx == 15);
      rel  = m_held && bus.i_FFT_cycle_done;
      pres = !m_held && (m_nfull > 0);
      if (acc) begin
        m_cur_re[m_widx*WORD_SIZE +: WORD_SIZE] = bus.i_sample_re;
        m_cur_im[m_widx*WORD_SIZE +: WORD_SIZE] = bus.i_sample_im;
        m_widx = (m_widx + 1) % 16;
        seq++;
      end
      if (rel && fq_re.size() > 0) begin
        void'(fq_re.pop_front());
        void'(fq_im.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (fill) begin
        fq_re.push_back(m_cur_re);
        fq_im.push_back(m_cur_im);
      end
      m_nfull = m_nfull + int'(fill) - int'(rel);
      m_start = pres;
      m_held  = m_held ? !rel : pres;
    end
    exp_re = (m_held && fq_re.size() > 0) ? fq_re[0] : '0;
    exp_im = (m_held && fq_im.size() > 0) ? fq_im[0] : '0;
    check("ready",       FW'(bus.o_sample_ready), FW'(m_nfull < 2));
    check("frame_valid", FW'(bus.o_frame_valid),  FW'(m_held));
    check("frame_start", FW'(bus.o_frame_start),  FW'(m_start));
    check("frames_done", FW'(bus.o_frames_done),  FW'(m_cnt));
    check("frame_re",    bus.o_frame_re, exp_re);
    check("frame_im",    bus.o_frame_im, exp_im);
    drive_sample();
  endtask

  initial begin
    logic [FW-1:0] fr;
    //        cyc rst val done  rdy vld st fd
    ph[0]  = '{2,  1, 0, 0,    1, 0, 0, 16'd0};
    ph[1]  = '{16, 0, 1, 0,    1, 0, 0, 16'd0};
    ph[2]  = '{1,  0, 0, 0,    1, 1, 1, 16'd0};
    ph[3]  = '{1,  0, 0, 0,    1, 1, 0, 16'd0};
    ph[4]  = '{1,  0, 0, 1,    1, 0, 0, 16'd1};
    ph[5]  = '{3,  0, 0, 1,    1, 0, 0, 16'd1};
    ph[6]  = '{32, 0, 1, 0,    0, 1, 0, 16'd1};
    ph[7]  = '{3,  0, 1, 0,    0, 1, 0, 16'd1};
    ph[8]  = '{1,  0, 1, 1,    1, 0, 0, 16'd2};
    ph[9]  = '{1,  0, 1, 0,    1, 1, 1, 16'd2};
    ph[10] = '{14, 0, 1, 0,    1, 1, 0, 16'd2};
    ph[11] = '{1,  0, 1, 1,    1, 0, 0, 16'd3};
    ph[12] = '{1,  0, 0, 0,    1, 1, 1, 16'd3};
    ph[13] = '{7,  0, 1, 0,    1, 1, 0, 16'd3};
    ph[14] = '{1,  1, 0, 0,    1, 0, 0, 16'd0};
    ph[15] = '{16, 0, 1, 0,    1, 0, 0, 16'd0};
    ph[16] = '{1,  0, 0, 0,    1, 1, 1, 16'd0};
    ph[17] = '{1,  0, 0, 1,    1, 0, 0, 16'd1};

    bus.i_sample_valid   = 1'b0;
    bus.i_FFT_cycle_done = 1'b0;
    drive_sample();

    for (int i = 0; i < 18; i++) begin
      rst                  = ph[i].rst;
      bus.i_sample_valid   = ph[i].valid;
      bus.i_FFT_cycle_done = ph[i].done;
      for (int c = 0; c < ph[i].cyc; c++) step();
      check($sformatf("ph%0d_ready", i), FW'(bus.o_sample_ready), FW'(ph[i].e_ready));
      check($sformatf("ph%0d_valid", i), FW'(bus.o_frame_valid),  FW'(ph[i].e_valid));
      check($sformatf("ph%0d_start", i), FW'(bus.o_frame_start),  FW'(ph[i].e_start));
      check($sformatf("ph%0d_fd", i),    FW'(bus.o_frames_done),  FW'(ph[i].e_fd));
      if (i == 2) begin
        fr = bus.o_frame_re;
        check("slot0_re",  FW'(fr[0 +: 16]),   FW'(16'h0000));
        check("slot15_re", FW'(fr[240 +: 16]), FW'(16'h0F00));
        fr = bus.o_frame_im;
        check("slot0_im",  FW'(fr[0 +: 16]),   FW'(16'h0000));
        check("slot1_im",  FW'(fr[16 +: 16]),  FW'(16'hFFFF));
        check("slot15_im", FW'(fr[240 +: 16]), FW'(16'hFFF1));
      end
    end

    // Sustained streaming with the FFT releasing every held frame immediately
    bus.i_sample_valid   = 1'b1;
    bus.i_FFT_cycle_done = 1'b1;
    for (int c = 0; c < 120; c++) step();

    // Drain with random done pulses
    bus.i_sample_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.i_FFT_cycle_done = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_FFT_cycle_done = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("drained_valid", FW'(bus.o_frame_valid), FW'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft16_frame_loader.md
# fft16_frame_loader

Upstream feeder for `FFT16_top`. It accepts a serial stream of complex fixed-point samples over a valid/ready handshake and packs every 16 consecutive samples into one frame. Two frame banks give ping-pong buffering: one bank fills while the other is held stable on the 16 parallel FFT inputs. The FFT's `o_FFT_cycle_done` releases the held bank back for filling.

## Interface
- `WORD_SIZE`, 16, bits per real/imag component, two's complement (Q(WORD_SIZE-FRACTION).FRACTION)
- `FRACTION`, 8, fractional bits; pass-through only, no arithmetic performed
- `POINTS`, 16, samples per frame; fixed at 16, the index is 4 bits
- `i_clk`  in  1  sole clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_sample_re`  in  WORD_SIZE  real part of the incoming sample
- `i_sample_im`  in  WORD_SIZE  imaginary part of the incoming sample
- `i_sample_valid`  in  1  sample present on the inputs
- `o_sample_ready`  out  1  loader can accept a sample this cycle
- `o_frame_re`  out  POINTS*WORD_SIZE  sample k at `[k*WORD_SIZE +: WORD_SIZE]`; k=0 is the oldest sample, wired to `in0_re`
- `o_frame_im`  out  POINTS*WORD_SIZE  same layout, wired to the `*_im` inputs
- `o_frame_valid`  out  1  held frame is stable and owned by the FFT
- `o_frame_start`  out  1  one-cycle pulse on the first cycle of each `o_frame_valid` assertion
- `i_FFT_cycle_done`  in  1  FFT finished with the held frame; connects to `FFT16_top.o_FFT_cycle_done`
- `o_frames_done`  out  16  count of released frames; wraps from 0xFFFF to 0

## Operation
- State registers:
  - `fill_bank` (1b), `wr_idx` (4b), `bank_full[1:0]`, `pres_bank` (1b), `o_frame_valid`, `o_frame_start`, `o_frames_done`.
- Accept:
  - `o_sample_ready = !bank_full[fill_bank]` (combinational from registers; does not depend on `i_sample_valid`).
  - On `i_sample_valid && o_sample_ready`, write sample to `bank[fill_bank][wr_idx]`, then `wr_idx++`.
- Fill complete:
  - When the accepted sample has `wr_idx==15`, set `bank_full[fill_bank]`, toggle `fill_bank`, and set `wr_idx` to 0 (4-bit wrap).
- Present:
  - When `!o_frame_valid && bank_full[pres_bank]`, set `o_frame_valid` and pulse `o_frame_start`.
- Release:
  - When `o_frame_valid && i_FFT_cycle_done`, clear `bank_full[pres_bank]`, toggle `pres_bank`, clear `o_frame_valid`, and increment `o_frames_done`.
  - The next frame can be presented no earlier than the following cycle, so there is at least one invalid cycle between frames.
- `i_FFT_cycle_done` while `!o_frame_valid` is ignored.
- Same-cycle fill-complete into bank X and release of bank Y (X≠Y): both updates apply.
  - Fill-complete and release can never target the same bank, because a presented bank is full and not fillable.
- Both banks full: `o_sample_ready=0` until a release. No sample is ever dropped or overwritten.
- `o_frame_re`/`o_frame_im` are zero whenever `o_frame_valid=0`. While valid, they equal `bank[pres_bank]` and do not change.
- Reset (at any time, including mid-frame):
  - The partial frame is discarded.
  - All state registers clear to 0; `fill_bank=pres_bank=0`.
  - Bank contents are not reset; they are unobservable because of the output gating.
  - Cleared outputs: `o_sample_ready=1`, `o_frame_valid=0`, `o_frame_start=0`, `o_frame_re=o_frame_im=0`, `o_frames_done=0`.
  - Resulting reset output values: `o_sample_ready=1`, all other outputs 0.

## Timing
- Throughput: one sample per cycle with no bubbles while a bank is free. Sustained rate is 16 samples per 16 cycles, provided the FFT releases within 16 cycles of presentation.
- Latency:
  - 16th sample accepted at edge E → `bank_full` set after E.
  - `o_frame_valid` and `o_frame_start` high after edge E+1, when the other bank is not presented.
- Release:
  - Done sampled at edge D → `o_frame_valid` low after D.
  - A waiting full bank is presented after D+1.
  - `o_sample_ready` for the freed bank rises after D.
- No combinational path from any input to any output.

## Structure
- Package `fft16_pkg`: `WORD_SIZE`, `FRACTION`, `POINTS` localparams; `fft_idx_t` (4-bit index).
- Sub-module `fft16_frame_bank`: 16×complex register file with a single write port (`we`, `idx`, `re`, `im`) and a flattened full-width read. The loader instantiates it twice.
- The loader holds the control FSM, the output mux/gating, and the counter.

## Test plan
- Reset, then stream samples re=k·0x0100, im=−k (k=0..15) with valid held high → `o_frame_valid` two edges after the 16th accept. Slot k holds re=k·0x0100, im=0xFFFF−k+1 (k>0), 0 for k=0. `o_frame_start` pulses exactly once.
- Stream 48 samples back-to-back with done never asserted → ready falls after the 32nd accept. Assert done → first frame released, `o_frames_done=1`, the second frame is presented one cycle later, ready rises, and samples 33–48 fill the freed bank.
- Assert done on the same edge that the 16th sample of the other bank is accepted → both take effect; the next frame is valid two cycles later with no lost sample.
- Pulse done while `o_frame_valid=0` → no state change, `o_frames_done` unchanged.
- Assert `i_rst` after 7 accepted samples → next frame contains only post-reset samples. All outputs read reset values the cycle after reset.
- Run 65536 frames with 1-cycle done → `o_frames_done` wraps to 0.
